// File: rtl/data_mem_initiator_if.sv
// Core request/response and data-memory signal bundle for data_mem_initiator.
// Revision 1.0
`default_nettype none

interface data_mem_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  // Initiator view: serves the core, drives the memory.
  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write, mem_address, mem_write_data
  );

  // Environment view: core plus data memory.
  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write, mem_address, mem_write_data
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_initiator.sv
// data_mem_initiator: byte/half/word load-store initiator for a word-only data memory.
// Revision 1.0
`default_nettype none

module data_mem_initiator #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  wire                  clk,
  input  wire                  reset_n,
  data_mem_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_write_data_q, mem_write_data_d;

  logic              w_req_err;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merged;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  always_comb begin
    w_req_err = 1'b0;
    case (bus.req_size)
      c_SZ_HALF: w_req_err = bus.req_addr[0];
      c_SZ_WORD: w_req_err = (bus.req_addr[1:0] != 2'b00);
      c_SZ_BYTE: w_req_err = 1'b0;
      default:   w_req_err = 1'b1;
    endcase
    if (bus.req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS)) begin
      w_req_err = 1'b1;
    end
  end

  // Little-endian lane selection from the word currently on the read bus.
  always_comb begin
    case (off_q)
      2'd0:    w_byte = bus.mem_read_data[7:0];
      2'd1:    w_byte = bus.mem_read_data[15:8];
      2'd2:    w_byte = bus.mem_read_data[23:16];
      default: w_byte = bus.mem_read_data[31:24];
    endcase
    w_half = off_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

    case (size_q)
      c_SZ_BYTE: w_load_ext = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load_ext = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default:   w_load_ext = bus.mem_read_data;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_read_data;
    if (size_q == c_SZ_BYTE) begin
      case (off_q)
        2'd0:    w_merged[7:0]   = wdata_q[7:0];
        2'd1:    w_merged[15:8]  = wdata_q[7:0];
        2'd2:    w_merged[23:16] = wdata_q[7:0];
        default: w_merged[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      w_merged[31:16] = wdata_q[15:0];
    end else begin
      w_merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    size_d           = size_q;
    uns_d            = uns_q;
    off_d            = off_q;
    wdata_d          = wdata_q;
    resp_rdata_d     = resp_rdata_q;
    resp_err_d       = resp_err_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d          = bus.req_we;
          size_d        = bus.req_size;
          uns_d         = bus.req_unsigned;
          off_d         = bus.req_addr[1:0];
          wdata_d       = bus.req_wdata;
          mem_address_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
          if (w_req_err) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
            state_d      = RESP;
          end else begin
            // Word stores present their data during ACCESS, so stage it now.
            if (bus.req_we && (bus.req_size == c_SZ_WORD)) begin
              mem_write_data_d = bus.req_wdata;
            end
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          resp_rdata_d = w_load_ext;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else if (size_q == c_SZ_WORD) begin
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else begin
          mem_write_data_d = w_merged;
          state_d          = MERGE_WR;
        end
      end
      MERGE_WR: begin
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      size_q           <= 2'b00;
      uns_q            <= 1'b0;
      off_q            <= 2'b00;
      wdata_q          <= 32'd0;
      resp_rdata_q     <= 32'd0;
      resp_err_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      size_q           <= size_d;
      uns_q            <= uns_d;
      off_q            <= off_d;
      wdata_q          <= wdata_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_err_q       <= resp_err_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // Strobe is decoded only from registers, so reset removes it asynchronously.
  assign bus.mem_write      = ((state_q == ACCESS) && we_q && (size_q == c_SZ_WORD)) ||
                              (state_q == MERGE_WR);
  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = (state_q == RESP);
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_initiator.sv
// Directed self-checking bench for data_mem_initiator with a 64-word memory model.
// Revision 1.0
`default_nettype none

module tb_data_mem_initiator;

  localparam int ADDR_W = 32;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  logic [31:0] mem [0:63];

  data_mem_initiator_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_initiator #(
    .MEM_WORDS(64),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (bus.mem_address[31:8] == 24'd0) bus.mem_read_data = mem[bus.mem_address[7:2]];
    else                                bus.mem_read_data = 32'd0;
  end

  always @(posedge clk) begin
    if (bus.mem_write && (bus.mem_address[31:8] == 24'd0)) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One request issued from IDLE; observes the transaction at each falling edge.
  task automatic run(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_nwr, input int exp_wr_at, input logic [31:0] exp_wr_data);
    logic [31:0] rdata, wr_data, wr_addr;
    logic        err;
    int          lat, nwr, wr_at;
    rdata = 32'd0; wr_data = 32'd0; wr_addr = 32'd0; err = 1'b0;
    lat = 0; nwr = 0; wr_at = 0;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, ".idle_rv"}, {31'd0, bus.resp_valid}, 32'd0);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.mem_write) begin
        nwr++;
        if (wr_at == 0) wr_at = k;
        wr_data = bus.mem_write_data;
        wr_addr = bus.mem_address;
      end
      if (bus.resp_valid) begin
        lat = k; rdata = bus.resp_rdata; err = bus.resp_err;
      end
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, ".nwr"}, nwr, exp_nwr);
    if (exp_nwr != 0) begin
      check({tag, ".wr_at"}, wr_at, exp_wr_at);
      check({tag, ".wr_data"}, wr_data, exp_wr_data);
      check({tag, ".wr_addr"}, wr_addr, {addr[31:2], 2'b00});
    end
  endtask

  logic [31:0] b2b_exp [0:5];
  int          acc_cyc [0:5];

  initial begin
    int nacc, nresp;
    logic acc;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    check("rst.resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst.mem_write", {31'd0, bus.mem_write}, 32'd0);
    check("rst.mem_address", bus.mem_address, 32'd0);
    check("rst.mem_wdata", bus.mem_write_data, 32'd0);
    reset_n = 1'b1;

    // word store then load
    run("sw1", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 1, 32'hDEADBEEF);
    run("lw1", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0, 32'h0);

    // byte read-modify-write
    run("sw2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'd0, 1'b0, 2, 1, 1, 32'h11223344);
    run("sb2", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'd0, 1'b0, 3, 1, 2, 32'h1122AA44);
    run("lb2", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 0, 32'h0);
    run("lbu2", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0, 0, 32'h0);

    // halfword read-modify-write
    run("sh3", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'd0, 1'b0, 3, 1, 2, 32'h8001AA44);
    run("lh3", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2, 0, 0, 32'h0);
    run("lhu3", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AA44, 1'b0, 2, 0, 0, 32'h0);

    // error cases
    run("e_lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'd0, 1'b1, 1, 0, 0, 32'h0);
    run("e_lh11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'd0, 1'b1, 1, 0, 0, 32'h0);
    run("e_sz11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'd0, 1'b1, 1, 0, 0, 32'h0);
    run("e_sw100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'd0, 1'b1, 1, 0, 0, 32'h0);
    check("e_sw100.mem0", mem[0], 32'd0);

    // reset during MERGE_WR of SB 0x55 @0x10
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstmw.access_wr", {31'd0, bus.mem_write}, 32'd0);
    @(posedge clk);
    #1 check("rstmw.merge_wr", {31'd0, bus.mem_write}, 32'd1);
    check("rstmw.merge_data", bus.mem_write_data, 32'h8001AA55);
    reset_n = 1'b0;
    #1 check("rstmw.wr_drop", {31'd0, bus.mem_write}, 32'd0);
    repeat (2) @(negedge clk);
    check("rstmw.no_resp", {31'd0, bus.resp_valid}, 32'd0);
    check("rstmw.mem_word", mem[4], 32'h8001AA44);
    reset_n = 1'b1;
    #1 check("rstmw.ready", {31'd0, bus.req_ready}, 32'd1);
    run("rstmw.lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8001AA44, 1'b0, 2, 0, 0, 32'h0);

    // back-to-back loads with req_valid held high
    b2b_exp[0] = 32'h01234567; b2b_exp[1] = 32'h89ABCDEF; b2b_exp[2] = 32'hFEDCBA98;
    b2b_exp[3] = 32'h76543210; b2b_exp[4] = 32'h0F0F0F0F; b2b_exp[5] = 32'hF0F0F0F0;
    for (int i = 0; i < 6; i++) begin
      run("b2b.pre", 1'b1, 2'b10, 1'b0, 32'h20 + 32'(4 * i), b2b_exp[i],
          32'd0, 1'b0, 2, 1, 1, b2b_exp[i]);
    end
    nacc = 0; nresp = 0;
    for (int i = 0; i < 6; i++) acc_cyc[i] = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h20;
    for (int c = 0; c < 40 && nresp < 6; c++) begin
      if (bus.resp_valid) begin
        check("b2b.rdata", bus.resp_rdata, b2b_exp[nresp]);
        nresp++;
      end
      if (bus.req_valid && !bus.req_ready && nacc > 0 && (c - acc_cyc[nacc-1]) >= 3) begin
        check("b2b.ready_late", {31'd0, bus.req_ready}, 32'd1);
      end
      acc = bus.req_valid && bus.req_ready;
      if (acc && nacc < 6) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (nacc < 6) bus.req_addr = 32'h20 + 32'(4 * nacc);
        else          bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b.naccepts", nacc, 6);
    check("b2b.nresp", nresp, 6);
    for (int i = 1; i < 6; i++) begin
      check("b2b.spacing", acc_cyc[i] - acc_cyc[0], 3 * i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
